sid_filter_sched: RTL and testbench
===================================

Name: sid_filter_sched

Overview:
- Sequencer and time-multiplexer that shares one sid_filter datapath between N_SID SID instances.
- Each sample tick, it runs one full 7-stage filter pass per instance, back to back.
- Between passes it stores each instance's filter state (vhp, vbp, vlp) and captures its audio output.
- Sits between the per-SID voice/register logic and the single sid_filter instance in the top level.

Parameters:
- N_SID, 2, number of SID instances sharing the filter (1..4).
- SEL_W, $clog2(N_SID) (min 1), width of the instance select.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- tick  in  1  one-cycle pulse requesting a filter sweep over all instances (one per SID cycle).
- clear  in  1  synchronous zeroing of all stored filter state.
- state_i  in  48  sid_filter state_o, packed {vhp, vbp, vlp}, signed 16 each.
- audio_i  in  24  sid_filter audio_o.
- stage  out  3  drives sid_filter stage.
- sel  out  SEL_W  instance currently owning the filter; the top level muxes filter_i inputs with it.
- state_o  out  48  stored state of instance sel, packed {vhp, vbp, vlp}; drives filter_i.state.
- audio_o  out  24*N_SID  latest audio per instance; instance k at [24k +: 24].
- audio_valid  out  1  one-cycle pulse: all audio_o slots updated by the sweep just finished.
- busy  out  1  sweep in progress.
- overrun  out  1  sticky; a tick was lost.

Behaviour:
- Reset values: stage=0, sel=0, all stored state=0, audio_o=0, audio_valid=0, busy=0, overrun=0, pending=0, FSM=IDLE.
- FSM states:
  - IDLE: stage=0.
  - RUN: stage counts 1..7, one per cycle.
  - WB: write-back, stage=0.
- Transitions:
  - IDLE -> RUN(stage=1, sel=0) the cycle after tick=1.
  - RUN stage 7 -> WB.
  - WB with sel<N_SID-1 -> RUN(stage=1, sel+1).
  - WB with sel=N_SID-1 -> RUN(stage=1, sel=0) if pending or tick is high that cycle; else IDLE with sel=0.
- Write-back: at the clock edge ending WB, state_mem[sel] <= state_i and audio slot sel <= audio_i. sid_filter has already registered state and audio on the stage 4/5/6/7 edges, so no extra latency is needed.
- state_o is combinational from state_mem[sel]. It must not change during RUN: state_mem[sel] is written only in WB.
- Timing for tick at cycle T: busy=1 from T+1 to T+8*N_SID. audio_valid=1 at T+8*N_SID+1. busy=0 at that cycle unless a new sweep starts.
- Sweep length is exactly 8*N_SID cycles; the minimum tick period is 8*N_SID.
- Tick while busy (including the final WB cycle): sets pending.
  - If pending is already set, the tick is dropped and overrun sets.
  - pending clears when the next sweep starts.
  - A tick in the same cycle a pending sweep starts re-sets pending.
- overrun stays set until rst.
- clear=1: all state_mem entries become 0 at that edge and override a same-cycle write-back. Audio slots and the sweep are unaffected.
- rst mid-sweep: abort immediately to reset values; the partial pass is discarded.
- audio_valid pulses once per completed sweep, including back-to-back sweeps.
- N_SID=1: sel stays 0 and the sweep is 8 cycles.

Test Plan:
- Single tick, N_SID=2, tick at cycle 10 -> stage sequence 1..7,0,1..7,0 over cycles 11-26; sel=0 for cycles 11-18 and 1 for cycles 19-26; busy high 11-26; audio_valid pulses at 27.
- Model state_i=0x1111_2222_3333 during sel=0 and 0x4444_5555_6666 during sel=1, audio_i=0x00ABC0 / 0x0DEF00 -> next sweep shows state_o=0x111122223333 while sel=0 and 0x444455556666 while sel=1; audio_o = {0x0DEF00, 0x00ABC0}.
- Tick every 16 cycles -> continuous back-to-back sweeps; stage never idles; audio_valid every 16 cycles; overrun=0.
- Three ticks within one sweep -> one pending sweep runs; overrun=1 and stays 1 until rst.
- clear asserted in the WB cycle for sel=1 -> both stored states read 0 on the next sweep; audio slot 1 still updated.
- rst at stage 4 of sel=1 -> next cycle stage=0, sel=0, busy=0, all outputs 0; a tick then runs a normal sweep from sel=0.

Source files
------------

// File: rtl/sid_filter_sched_if.sv
// Bus between the shared sid_filter datapath, the per-SID logic and the filter scheduler.
interface sid_filter_sched_if #(
  parameter int unsigned N_SID = 2,
  parameter int unsigned SEL_W = (N_SID > 1) ? $clog2(N_SID) : 1
);
  logic                   tick;
  logic                   clear;
  logic [47:0]            state_i;
  logic [23:0]            audio_i;
  logic [2:0]             stage;
  logic [SEL_W-1:0]       sel;
  logic [47:0]            state_o;
  logic [24*N_SID-1:0]    audio_o;
  logic                   audio_valid;
  logic                   busy;
  logic                   overrun;

  modport master (
    input  tick, clear, state_i, audio_i,
    output stage, sel, state_o, audio_o, audio_valid, busy, overrun
  );

  modport slave (
    output tick, clear, state_i, audio_i,
    input  stage, sel, state_o, audio_o, audio_valid, busy, overrun
  );
endinterface

// File: rtl/sid_filter_sched.sv
// Time-multiplexes one 7-stage sid_filter across N_SID instances: one pass per
// instance per tick, with per-instance filter state and audio held between passes.
module sid_filter_sched #(
  parameter int unsigned N_SID = 2,
  parameter int unsigned SEL_W = (N_SID > 1) ? $clog2(N_SID) : 1
) (
  input  logic                clk,
  input  logic                rst,
  sid_filter_sched_if.master  bus
);
  localparam int unsigned STAGE_W = 3;
  localparam int unsigned STATE_W = 48;
  localparam int unsigned AUDIO_W = 24;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  localparam logic [SEL_W-1:0]   LAST_SEL   = SEL_W'(N_SID - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(7);

  logic [1:0]         fsm_q, fsm_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               pending_q, pending_d;
  logic               overrun_q, overrun_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               wb_c;
  logic               last_wb_c;

  logic [STATE_W-1:0] state_mem [N_SID];
  logic [AUDIO_W-1:0] audio_q   [N_SID];

  assign last_wb_c = (fsm_q == ST_WB) && (sel_q == LAST_SEL);

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= ST_IDLE;
      stage_q   <= '0;
      sel_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      stage_q   <= stage_d;
      sel_q     <= sel_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  // Next-state: sweep sequencing and tick bookkeeping
  always_comb begin
    fsm_d     = fsm_q;
    stage_d   = stage_q;
    sel_d     = sel_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    wb_c      = 1'b0;

    // A tick arriving mid-sweep queues one sweep; a second one is lost.
    if (bus.tick && (fsm_q != ST_IDLE) && !last_wb_c) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end

    case (fsm_q)
      ST_IDLE: begin
        if (bus.tick) begin
          fsm_d   = ST_RUN;
          stage_d = STAGE_W'(1);
          sel_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (stage_q == LAST_STAGE) begin
          fsm_d   = ST_WB;
          stage_d = '0;
        end else begin
          stage_d = stage_q + STAGE_W'(1);
        end
      end
      ST_WB: begin
        wb_c = 1'b1;
        if (!last_wb_c) begin
          fsm_d   = ST_RUN;
          stage_d = STAGE_W'(1);
          sel_d   = sel_q + SEL_W'(1);
        end else begin
          valid_d = 1'b1;
          sel_d   = '0;
          if (pending_q || bus.tick) begin
            // A tick that coincides with draining the queue re-queues itself.
            fsm_d     = ST_RUN;
            stage_d   = STAGE_W'(1);
            pending_d = pending_q && bus.tick;
          end else begin
            fsm_d  = ST_IDLE;
            busy_d = 1'b0;
          end
        end
      end
      default: begin
        fsm_d   = ST_IDLE;
        stage_d = '0;
        sel_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Per-instance filter state and audio; clear wins over a same-edge write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(N_SID); k++) begin
        state_mem[k] <= '0;
        audio_q[k]   <= '0;
      end
    end else begin
      if (bus.clear) begin
        for (int k = 0; k < int'(N_SID); k++) state_mem[k] <= '0;
      end else if (wb_c) begin
        state_mem[sel_q] <= bus.state_i;
      end
      if (wb_c) audio_q[sel_q] <= bus.audio_i;
    end
  end

  for (genvar k = 0; k < int'(N_SID); k++) begin : g_audio
    assign bus.audio_o[AUDIO_W*k +: AUDIO_W] = audio_q[k];
  end

  assign bus.stage       = stage_q;
  assign bus.sel         = sel_q;
  assign bus.state_o     = state_mem[sel_q];
  assign bus.audio_valid = valid_q;
  assign bus.busy        = busy_q;
  assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_sid_filter_sched.sv
// Directed bench for sid_filter_sched with N_SID=2 and a simple per-instance filter model.
module tb_sid_filter_sched;
  localparam int unsigned N_SID = 2;
  localparam int unsigned SEL_W = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sid_filter_sched_if #(.N_SID(N_SID), .SEL_W(SEL_W)) bus ();
  sid_filter_sched #(.N_SID(N_SID), .SEL_W(SEL_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [47:0] st0, st1;
  logic [23:0] au0, au1;

  // Filter model: presents the state/audio of whichever instance owns the datapath.
  always_comb begin
    bus.state_i = (bus.sel == 1'b0) ? st0 : st1;
    bus.audio_i = (bus.sel == 1'b0) ? au0 : au1;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       tick;
    logic [2:0] stage;
    logic       sel;
    logic       busy;
    logic       valid;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(logic t, logic [2:0] st, logic s, logic b, logic v);
    vec_t r;
    r.tick = t; r.stage = st; r.sel = s; r.busy = b; r.valid = v;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!bus.audio_valid && n < max) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    int stage_err, idle_cnt, vcnt;
    logic [2:0] exp_stage;

    tbl[0]  = mk(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 3'd1, 1'b0, 1'b1, 1'b0);
    tbl[2]  = mk(1'b0, 3'd2, 1'b0, 1'b1, 1'b0);
    tbl[3]  = mk(1'b0, 3'd3, 1'b0, 1'b1, 1'b0);
    tbl[4]  = mk(1'b0, 3'd4, 1'b0, 1'b1, 1'b0);
    tbl[5]  = mk(1'b0, 3'd5, 1'b0, 1'b1, 1'b0);
    tbl[6]  = mk(1'b0, 3'd6, 1'b0, 1'b1, 1'b0);
    tbl[7]  = mk(1'b0, 3'd7, 1'b0, 1'b1, 1'b0);
    tbl[8]  = mk(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    tbl[9]  = mk(1'b0, 3'd1, 1'b1, 1'b1, 1'b0);
    tbl[10] = mk(1'b0, 3'd2, 1'b1, 1'b1, 1'b0);
    tbl[11] = mk(1'b0, 3'd3, 1'b1, 1'b1, 1'b0);
    tbl[12] = mk(1'b0, 3'd4, 1'b1, 1'b1, 1'b0);
    tbl[13] = mk(1'b0, 3'd5, 1'b1, 1'b1, 1'b0);
    tbl[14] = mk(1'b0, 3'd6, 1'b1, 1'b1, 1'b0);
    tbl[15] = mk(1'b0, 3'd7, 1'b1, 1'b1, 1'b0);
    tbl[16] = mk(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    tbl[17] = mk(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    tbl[18] = mk(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    st0 = 48'h1111_2222_3333;
    st1 = 48'h4444_5555_6666;
    au0 = 24'h00ABC0;
    au1 = 24'h0DEF00;
    rst = 1'b1;
    bus.tick = 1'b0;
    bus.clear = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    chk("rst_stage", 64'(bus.stage), 64'd0);
    chk("rst_sel", 64'(bus.sel), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_valid", 64'(bus.audio_valid), 64'd0);
    chk("rst_overrun", 64'(bus.overrun), 64'd0);
    chk("rst_audio", 64'(bus.audio_o), 64'd0);
    chk("rst_state_o", 64'(bus.state_o), 64'd0);
    repeat (6) step();

    // Single sweep, cycle by cycle
    for (int i = 0; i < 19; i++) begin
      bus.tick = tbl[i].tick;
      chk($sformatf("tbl%0d_stage", i), 64'(bus.stage), 64'(tbl[i].stage));
      chk($sformatf("tbl%0d_sel", i), 64'(bus.sel), 64'(tbl[i].sel));
      chk($sformatf("tbl%0d_busy", i), 64'(bus.busy), 64'(tbl[i].busy));
      chk($sformatf("tbl%0d_valid", i), 64'(bus.audio_valid), 64'(tbl[i].valid));
      step();
    end
    bus.tick = 1'b0;
    chk("sweep1_audio", 64'(bus.audio_o), 64'h0000_0DEF_0000_ABC0);

    // Stored state played back on the next sweep
    tick_once();
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("replay_state_k%0d", k), 64'(bus.state_o),
          (k <= 8) ? 64'h0000_1111_2222_3333 : 64'h0000_4444_5555_6666);
      step();
    end
    chk("replay_valid", 64'(bus.audio_valid), 64'd1);
    repeat (4) step();

    // Back-to-back sweeps with a tick every 16 cycles
    stage_err = 0; idle_cnt = 0; vcnt = 0;
    for (int k = 0; k <= 64; k++) begin
      bus.tick = (k % 16 == 0) && (k < 64);
      if (k >= 1) begin
        exp_stage = 3'(k % 8);
        if (bus.stage !== exp_stage) stage_err++;
        if (bus.busy !== 1'b1) idle_cnt++;
      end
      if (bus.audio_valid === 1'b1) vcnt++;
      step();
    end
    bus.tick = 1'b0;
    chk("b2b_stage_errs", 64'(stage_err), 64'd0);
    chk("b2b_idle_cycles", 64'(idle_cnt), 64'd0);
    chk("b2b_valid_count", 64'(vcnt), 64'd3);
    chk("b2b_final_valid", 64'(bus.audio_valid), 64'd1);
    chk("b2b_final_busy", 64'(bus.busy), 64'd0);
    chk("b2b_overrun", 64'(bus.overrun), 64'd0);
    repeat (4) step();

    // Three ticks in one sweep: one queued sweep, one lost tick
    for (int k = 0; k <= 33; k++) begin
      bus.tick = (k == 0) || (k == 3) || (k == 5);
      if (k == 5) chk("ovr_before", 64'(bus.overrun), 64'd0);
      if (k == 6) chk("ovr_after", 64'(bus.overrun), 64'd1);
      if (k == 17) begin
        chk("ovr_valid1", 64'(bus.audio_valid), 64'd1);
        chk("ovr_busy17", 64'(bus.busy), 64'd1);
        chk("ovr_stage17", 64'(bus.stage), 64'd1);
      end
      if (k == 33) begin
        chk("ovr_valid2", 64'(bus.audio_valid), 64'd1);
        chk("ovr_busy33", 64'(bus.busy), 64'd0);
      end
      step();
    end
    bus.tick = 1'b0;
    repeat (10) step();
    chk("ovr_sticky", 64'(bus.overrun), 64'd1);

    // clear during the final write-back zeroes both states, audio still lands
    au1 = 24'h0AAAAA;
    for (int k = 0; k <= 17; k++) begin
      bus.tick = (k == 0);
      bus.clear = (k == 16);
      if (k == 17) begin
        chk("clr_valid", 64'(bus.audio_valid), 64'd1);
        chk("clr_audio", 64'(bus.audio_o), 64'h0000_0AAA_AA00_ABC0);
      end
      step();
    end
    bus.tick = 1'b0;
    bus.clear = 1'b0;
    repeat (3) step();
    tick_once();
    chk("clr_sel0_state", 64'(bus.state_o), 64'd0);
    repeat (8) step();
    chk("clr_sel1_sel", 64'(bus.sel), 64'd1);
    chk("clr_sel1_state", 64'(bus.state_o), 64'd0);
    wait_valid(40, n);
    chk("clr_sweep_done", 64'(bus.audio_valid), 64'd1);
    repeat (4) step();

    // rst at stage 4 of sel=1 aborts the sweep
    tick_once();
    repeat (11) step();
    chk("abort_pre_stage", 64'(bus.stage), 64'd4);
    chk("abort_pre_sel", 64'(bus.sel), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_stage", 64'(bus.stage), 64'd0);
    chk("abort_sel", 64'(bus.sel), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_valid", 64'(bus.audio_valid), 64'd0);
    chk("abort_overrun", 64'(bus.overrun), 64'd0);
    chk("abort_audio", 64'(bus.audio_o), 64'd0);
    chk("abort_state_o", 64'(bus.state_o), 64'd0);
    step();
    tick_once();
    chk("post_stage", 64'(bus.stage), 64'd1);
    chk("post_sel", 64'(bus.sel), 64'd0);
    chk("post_busy", 64'(bus.busy), 64'd1);
    wait_valid(40, n);
    chk("post_latency", 64'(n), 64'd16);
    chk("post_audio", 64'(bus.audio_o), 64'h0000_0AAA_AA00_ABC0);
    step();
    chk("post_valid_pulse", 64'(bus.audio_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
